// File: rtl/axi_mm2s_reader_if.sv
// AXI4 read channels (AR + R) plus the outgoing AXI-Stream, bundled for the
// mm2s reader. The master modport is the reader's view; slave is the view
// of whatever sits on the other side (memory on AR/R, consumer on the stream).
interface axi_mm2s_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 1
) ();
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // read address channel
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic                  m_axi_arlock;
  logic [3:0]            m_axi_arcache;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  // read data channel
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  // outgoing stream
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [STRB_WIDTH-1:0] m_axis_tkeep;
  logic                  m_axis_tlast;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rid, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rid, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/axi_mm2s_reader.sv
// AXI4 read master: splits a word-count command into INCR bursts (one in
// flight, never crossing 4 KB) and forwards the returned beats through a
// 2-entry skid buffer onto an AXI-Stream, tlast on the command's final word.
module axi_mm2s_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 1,
  parameter int ARID_VALUE    = 0,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [15:0]           cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  axi_mm2s_reader_if.master     m,
  output logic                  busy,
  output logic                  done,
  output logic                  done_err
);

  localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(STRB_WIDTH - 1));

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  // Beats for the next burst: limited by words left, burst cap and 4 KB page room.
  function automatic logic [8:0] calc_beats(input logic [ADDR_WIDTH-1:0] a,
                                            input logic [15:0] rem);
    logic [16:0] room;
    logic [16:0] b;
    room = (17'd4096 - {5'd0, a[11:0]}) >> BYTE_SHIFT;
    b    = {1'b0, rem};
    b    = (b > 17'(MAX_BURST_LEN)) ? 17'(MAX_BURST_LEN) : b;
    b    = (b > room) ? room : b;
    return 9'(b);
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           rem_q, rem_d;
  logic [8:0]            beats_q, beats_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;
  logic [7:0]            arlen_q, arlen_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  done_err_q, done_err_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                  last0_q, last0_d, last1_q, last1_d;
  logic                  tvalid_q, tvalid_d;

  logic                  push_s, pop_s, beat_last_s, cmd_last_word_s;
  logic [8:0]            nb_s;
  logic [ADDR_WIDTH-1:0] next_addr_s, cmd_addr_al_s;
  logic [15:0]           next_rem_s;
  logic                  unused_s;

  assign unused_s        = ^m.m_axi_rid;
  assign push_s          = m.m_axi_rvalid && rready_q;
  assign pop_s           = tvalid_q && m.m_axis_tready;
  assign beat_last_s     = (beat_cnt_q == 9'd1);
  assign cmd_last_word_s = beat_last_s && (rem_q == {7'd0, beats_q});
  assign cmd_addr_al_s   = cmd_addr & ALIGN_MASK;
  assign next_addr_s     = addr_q + (ADDR_WIDTH'(beats_q) << BYTE_SHIFT);
  assign next_rem_s      = rem_q - {7'd0, beats_q};

  // Command sequencing: IDLE -> ADDR <-> DATA -> DONE, error tracking.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    arlen_d    = arlen_q;
    nb_s       = 9'd0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d = cmd_addr_al_s;
          rem_d  = cmd_len;
          err_d  = 1'b0;
          if (cmd_len == 16'd0) begin
            state_d = DONE;
          end else begin
            nb_s    = calc_beats(cmd_addr_al_s, cmd_len);
            beats_d = nb_s;
            arlen_d = 8'(nb_s - 9'd1);
            state_d = ADDR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (m.m_axi_arready) begin
          beat_cnt_d = beats_q;
          state_d    = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (push_s) begin
          beat_cnt_d = beat_cnt_q - 9'd1;
          if ((m.m_axi_rresp != 2'b00) || (m.m_axi_rlast != beat_last_s)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (beat_last_s) begin
            if (rem_q > {7'd0, beats_q}) begin
              nb_s    = calc_beats(next_addr_s, next_rem_s);
              addr_d  = next_addr_s;
              rem_d   = next_rem_s;
              beats_d = nb_s;
              arlen_d = 8'(nb_s - 9'd1);
              state_d = ADDR;
            end else begin
              state_d = DONE;
            end
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Skid buffer: entry 0 is the stream head; entry 1 holds a beat while stalled.
  always_comb begin
    cnt_d   = cnt_q;
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    case ({push_s, pop_s})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          data0_d = m.m_axi_rdata;
          last0_d = cmd_last_word_s;
        end else begin
          data1_d = m.m_axi_rdata;
          last1_d = cmd_last_word_s;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          data0_d = m.m_axi_rdata;
          last0_d = cmd_last_word_s;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = m.m_axi_rdata;
          last1_d = cmd_last_word_s;
        end
      end
      default: cnt_d = cnt_q;
    endcase
    tvalid_d = (cnt_d != 2'd0);
  end

  // Next values of the registered handshake and status outputs.
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    arvalid_d   = (state_d == ADDR);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    done_err_d  = (state_d == DONE) ? err_d : 1'b0;
    rready_d    = (state_d == DATA) && (cnt_d != 2'd2);
  end

  // All state and outputs are flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= 16'd0;
      beats_q     <= 9'd0;
      beat_cnt_q  <= 9'd0;
      err_q       <= 1'b0;
      arlen_q     <= 8'd0;
      cmd_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
      cnt_q       <= 2'd0;
      data0_q     <= '0;
      data1_q     <= '0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
      tvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      beats_q     <= beats_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      arlen_q     <= arlen_d;
      cmd_ready_q <= cmd_ready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_err_q  <= done_err_d;
      cnt_q       <= cnt_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      tvalid_q    <= tvalid_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign done_err        = done_err_q;
  assign m.m_axi_araddr  = addr_q;
  assign m.m_axi_arlen   = arlen_q;
  assign m.m_axi_arsize  = 3'(BYTE_SHIFT);
  assign m.m_axi_arburst = 2'b01;
  assign m.m_axi_arid    = ID_WIDTH'(ARID_VALUE);
  assign m.m_axi_arlock  = 1'b0;
  assign m.m_axi_arcache = 4'b0011;
  assign m.m_axi_arprot  = 3'b000;
  assign m.m_axi_arvalid = arvalid_q;
  assign m.m_axi_rready  = rready_q;
  assign m.m_axis_tdata  = data0_q;
  assign m.m_axis_tkeep  = {STRB_WIDTH{1'b1}};
  assign m.m_axis_tlast  = last0_q;
  assign m.m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axi_mm2s_reader.sv
// Bench for axi_mm2s_reader: behavioural AXI memory slave, random stream
// consumer, and queues of expected AR requests, stream words and done pulses.
module tb_axi_mm2s_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_valid;
  logic        cmd_ready, busy, done, done_err;

  always #5 clk = ~clk;

  axi_mm2s_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(1)) bus ();

  axi_mm2s_reader #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(1),
    .ARID_VALUE(0), .MAX_BURST_LEN(16)
  ) dut (
    .clk(clk), .rst(rst), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .m(bus),
    .busy(busy), .done(done), .done_err(done_err)
  );

  typedef struct { logic [15:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [31:0] data; logic last; } beat_t;
  typedef struct { bit err; bit zero; } done_t;

  ar_t   exp_ar_q[$];
  beat_t exp_s_q[$];
  done_t exp_done_q[$];
  ar_t   sl_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_r_cyc = 0;
  int prev_s_cyc = 0;
  int sl_beat = 0;
  int tready_hold = 0;
  bit tready_rand = 1'b0;
  bit fault_en = 1'b0;
  bit chk_gap = 1'b0;
  bit gap_first = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // memory image: word w holds 0xA000_0000 + (w - 0x40)
  function automatic logic [31:0] mem_word(input int w);
    return 32'hA000_0000 + 32'(w) - 32'h40;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AXI memory slave model; handshakes decided at negedge, driven #1 after posedge
  initial begin
    bit ar_fire, r_fire, rst_seen, ar_wait;
    logic [15:0] hold_addr;
    logic [7:0]  hold_len;
    ar_t e;
    int w;
    ar_wait = 1'b0;
    hold_addr = 16'd0;
    hold_len = 8'd0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata = 32'd0;
    bus.m_axi_rresp = 2'b00;
    bus.m_axi_rlast = 1'b0;
    bus.m_axi_rid = 1'b0;
    forever begin
      @(negedge clk);
      ar_fire  = bus.m_axi_arvalid && bus.m_axi_arready;
      r_fire   = bus.m_axi_rvalid && bus.m_axi_rready;
      rst_seen = rst;
      if (ar_wait && bus.m_axi_arvalid) begin
        check_eq("ar_stable_addr", bus.m_axi_araddr, hold_addr);
        check_eq("ar_stable_len", bus.m_axi_arlen, hold_len);
      end
      if (ar_fire) begin
        if (exp_ar_q.size() == 0) begin
          check_eq("ar_unexpected", 1, 0);
        end else begin
          e = exp_ar_q.pop_front();
          check_eq("araddr", bus.m_axi_araddr, e.addr);
          check_eq("arlen", bus.m_axi_arlen, e.len);
          check_eq("arsize", bus.m_axi_arsize, 3'd2);
          check_eq("arburst", bus.m_axi_arburst, 2'b01);
          check_eq("arcache", bus.m_axi_arcache, 4'b0011);
        end
        sl_q.push_back('{addr: bus.m_axi_araddr, len: bus.m_axi_arlen});
      end
      ar_wait   = bus.m_axi_arvalid && !bus.m_axi_arready;
      hold_addr = bus.m_axi_araddr;
      hold_len  = bus.m_axi_arlen;
      if (r_fire) last_r_cyc = cyc;
      @(posedge clk);
      #1;
      if (rst_seen) begin
        sl_q.delete();
        sl_beat = 0;
        ar_wait = 1'b0;
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast = 1'b0;
        bus.m_axi_arready = 1'b0;
      end else begin
        if (r_fire) begin
          sl_beat++;
          if (sl_beat > int'(sl_q[0].len)) begin
            void'(sl_q.pop_front());
            sl_beat = 0;
          end
        end
        if (!(bus.m_axi_rvalid && !r_fire)) begin
          if (sl_q.size() > 0) begin
            w = int'(sl_q[0].addr >> 2) + sl_beat;
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = mem_word(w);
            bus.m_axi_rlast  = (sl_beat == int'(sl_q[0].len));
            bus.m_axi_rresp  = (fault_en && sl_beat == 2) ? 2'b10 : 2'b00;
          end else begin
            bus.m_axi_rvalid = 1'b0;
            bus.m_axi_rlast  = 1'b0;
            bus.m_axi_rresp  = 2'b00;
          end
        end
        bus.m_axi_arready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // stream consumer and done monitor
  initial begin
    beat_t b;
    done_t d;
    bus.m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_s_q.size() == 0) begin
          check_eq("stream_extra", 1, 0);
        end else begin
          b = exp_s_q.pop_front();
          check_eq("tdata", bus.m_axis_tdata, b.data);
          check_eq("tlast", bus.m_axis_tlast, b.last);
          check_eq("tkeep", bus.m_axis_tkeep, 4'hF);
        end
        if (chk_gap) begin
          if (!gap_first) check_eq("stream_gap", cyc - prev_s_cyc, 1);
          gap_first = 1'b0;
          prev_s_cyc = cyc;
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          check_eq("done_unexpected", 1, 0);
        end else begin
          d = exp_done_q.pop_front();
          check_eq("done_err", done_err, d.err);
          if (!d.zero) check_eq("done_latency", cyc - last_r_cyc, 1);
        end
      end
      @(posedge clk);
      #1;
      if (tready_hold > 0) begin
        bus.m_axis_tready = 1'b0;
        tready_hold--;
      end else begin
        bus.m_axis_tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // push expectations, perform the command handshake, check first response timing
  task automatic start_cmd(input logic [15:0] a, input int len, input bit err);
    int rem, ad, b, room, i;
    bit got;
    rem = len;
    ad = int'(a) & 32'hFFFC;
    while (rem > 0) begin
      room = (4096 - (ad & 32'hFFF)) / 4;
      b = (rem < 16) ? rem : 16;
      b = (b < room) ? b : room;
      exp_ar_q.push_back('{addr: 16'(ad), len: 8'(b - 1)});
      for (i = 0; i < b; i++)
        exp_s_q.push_back('{data: mem_word(ad / 4 + i), last: (rem == b) && (i == b - 1)});
      ad = (ad + b * 4) & 32'hFFFF;
      rem = rem - b;
    end
    exp_done_q.push_back('{err: err, zero: (len == 0)});
    @(posedge clk);
    #1;
    cmd_addr = a;
    cmd_len = 16'(len);
    cmd_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = cmd_ready;
    end
    check_eq("cmd_accept", got, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    if (len == 0) begin
      check_eq("zero_done_n1", done, 1);
      check_eq("zero_no_ar", bus.m_axi_arvalid, 0);
    end else begin
      check_eq("ar_valid_n1", bus.m_axi_arvalid, 1);
      check_eq("busy_n1", busy, 1);
    end
  endtask

  task automatic wait_drain();
    int pending;
    pending = 1;
    for (int k = 0; k < 4000 && pending != 0; k++) begin
      @(negedge clk);
      pending = exp_ar_q.size() + exp_s_q.size() + exp_done_q.size();
    end
    check_eq("drain", pending, 0);
    @(negedge clk);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_cmd_ready", cmd_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 0);
    check_eq({tag, "_arvalid"}, bus.m_axi_arvalid, 0);
    check_eq({tag, "_rready"}, bus.m_axi_rready, 0);
    check_eq({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
    check_eq({tag, "_tlast"}, bus.m_axis_tlast, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_done_err"}, done_err, 0);
    check_eq({tag, "_arlen"}, bus.m_axi_arlen, 0);
    check_eq({tag, "_araddr"}, bus.m_axi_araddr, 0);
    check_eq({tag, "_tdata"}, bus.m_axis_tdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = 16'd0;
    cmd_len = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("cmd_ready_after_reset", cmd_ready, 1);

    // basic read, beats must stream back-to-back
    chk_gap = 1'b1;
    gap_first = 1'b1;
    start_cmd(16'h0100, 4, 1'b0);
    wait_drain();
    chk_gap = 1'b0;

    // burst splitting
    start_cmd(16'h0000, 40, 1'b0);
    wait_drain();

    // 4 KB boundary crossing
    start_cmd(16'h0FF8, 6, 1'b0);
    wait_drain();

    // backpressure: random tready plus a 10-cycle stall
    tready_rand = 1'b1;
    start_cmd(16'h0200, 32, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = bus.m_axis_tvalid;
    end
    check_eq("bp_tvalid_seen", seen, 1);
    tready_hold = 10;
    repeat (10) @(negedge clk);
    check_eq("bp_rready_full", bus.m_axi_rready, 0);
    check_eq("bp_tvalid_hold", bus.m_axis_tvalid, 1);
    wait_drain();
    tready_rand = 1'b0;

    // zero-length command
    start_cmd(16'h0300, 0, 1'b0);
    wait_drain();

    // error response on beat 3
    fault_en = 1'b1;
    start_cmd(16'h0100, 4, 1'b1);
    wait_drain();
    fault_en = 1'b0;

    // reset in the middle of a burst, then a normal command
    start_cmd(16'h0000, 40, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      seen = (exp_s_q.size() <= 34);
    end
    check_eq("mid_progress", seen, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    exp_ar_q.delete();
    exp_s_q.delete();
    exp_done_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_cmd(16'h0100, 2, 1'b0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
